// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct encodings, ALU op codes and the decoded control bundle.
package mips_defs;

  localparam int unsigned INSN_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned OPC_W  = 6;

  // Primary opcodes
  localparam logic [OPC_W-1:0] OP_OTHER0 = 6'h00;
  localparam logic [OPC_W-1:0] OP_J      = 6'h02;
  localparam logic [OPC_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE    = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI   = 6'h08;
  localparam logic [OPC_W-1:0] OP_ADDIU  = 6'h09;
  localparam logic [OPC_W-1:0] OP_ANDI   = 6'h0c;
  localparam logic [OPC_W-1:0] OP_ORI    = 6'h0d;
  localparam logic [OPC_W-1:0] OP_XORI   = 6'h0e;
  localparam logic [OPC_W-1:0] OP_LUI    = 6'h0f;
  localparam logic [OPC_W-1:0] OP_LW     = 6'h23;
  localparam logic [OPC_W-1:0] OP_LBU    = 6'h24;
  localparam logic [OPC_W-1:0] OP_SB     = 6'h28;
  localparam logic [OPC_W-1:0] OP_SW     = 6'h2b;

  // Funct codes under OP_OTHER0
  localparam logic [OPC_W-1:0] OP0_JR    = 6'h08;
  localparam logic [OPC_W-1:0] OP0_ADD   = 6'h20;
  localparam logic [OPC_W-1:0] OP0_ADDU  = 6'h21;
  localparam logic [OPC_W-1:0] OP0_SUB   = 6'h22;
  localparam logic [OPC_W-1:0] OP0_AND   = 6'h24;
  localparam logic [OPC_W-1:0] OP0_OR    = 6'h25;
  localparam logic [OPC_W-1:0] OP0_XOR   = 6'h26;
  localparam logic [OPC_W-1:0] OP0_NOR   = 6'h27;
  localparam logic [OPC_W-1:0] OP0_SLT   = 6'h2a;
  localparam logic [OPC_W-1:0] OP0_ADDM  = 6'h2c;

  // ALU control
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b011;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b101;
  localparam logic [ALU_W-1:0] ALU_NOR = 3'b110;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b111;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm16;
    logic [TGT_W-1:0] target26;
    logic [ALU_W-1:0] alu_op;
    logic             writeenable;
    logic             rd_src;
    logic             alu_src2;
    logic             except;
    logic             br_eq;
    logic             br_ne;
    logic             jump;
    logic             jump_reg;
    logic             mem_read;
    logic             word_we;
    logic             byte_we;
    logic             byte_load;
    logic             lui;
    logic             slt;
    logic             addm;
  } ctrl_t;

endpackage

// File: rtl/mips_decode_comb.sv
// Pure combinational decode of one instruction word into the control bundle.
module mips_decode_comb
  import mips_defs::*;
(
  input  logic [INSN_W-1:0] insn_i,
  output ctrl_t             ctrl_o
);

  logic [OPC_W-1:0] opcode;
  logic [OPC_W-1:0] funct;

  assign opcode = insn_i[31:26];
  assign funct  = insn_i[5:0];

  // Field extraction plus per-opcode control; anything unrecognised raises except
  always_comb begin
    ctrl_o          = '0;
    ctrl_o.rs       = insn_i[25:21];
    ctrl_o.rt       = insn_i[20:16];
    ctrl_o.rd       = insn_i[15:11];
    ctrl_o.imm16    = insn_i[15:0];
    ctrl_o.target26 = insn_i[25:0];
    case (opcode)
      OP_OTHER0: begin
        case (funct)
          OP0_ADD, OP0_ADDU: begin ctrl_o.alu_op = ALU_ADD; ctrl_o.writeenable = 1'b1; end
          OP0_SUB:  begin ctrl_o.alu_op = ALU_SUB; ctrl_o.writeenable = 1'b1; end
          OP0_AND:  begin ctrl_o.alu_op = ALU_AND; ctrl_o.writeenable = 1'b1; end
          OP0_OR:   begin ctrl_o.alu_op = ALU_OR;  ctrl_o.writeenable = 1'b1; end
          OP0_NOR:  begin ctrl_o.alu_op = ALU_NOR; ctrl_o.writeenable = 1'b1; end
          OP0_XOR:  begin ctrl_o.alu_op = ALU_XOR; ctrl_o.writeenable = 1'b1; end
          OP0_SLT:  begin ctrl_o.alu_op = ALU_SUB; ctrl_o.writeenable = 1'b1; ctrl_o.slt = 1'b1; end
          OP0_JR:   ctrl_o.jump_reg = 1'b1;
          OP0_ADDM: begin
            ctrl_o.alu_op      = ALU_ADD;
            ctrl_o.writeenable = 1'b1;
            ctrl_o.mem_read    = 1'b1;
            ctrl_o.addm        = 1'b1;
          end
          default:  ctrl_o.except = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_o.alu_op = ALU_ADD; ctrl_o.writeenable = 1'b1; ctrl_o.rd_src = 1'b1; ctrl_o.alu_src2 = 1'b1;
      end
      OP_ANDI: begin
        ctrl_o.alu_op = ALU_AND; ctrl_o.writeenable = 1'b1; ctrl_o.rd_src = 1'b1; ctrl_o.alu_src2 = 1'b1;
      end
      OP_ORI: begin
        ctrl_o.alu_op = ALU_OR; ctrl_o.writeenable = 1'b1; ctrl_o.rd_src = 1'b1; ctrl_o.alu_src2 = 1'b1;
      end
      OP_XORI: begin
        ctrl_o.alu_op = ALU_XOR; ctrl_o.writeenable = 1'b1; ctrl_o.rd_src = 1'b1; ctrl_o.alu_src2 = 1'b1;
      end
      OP_BEQ: begin ctrl_o.alu_op = ALU_SUB; ctrl_o.br_eq = 1'b1; end
      OP_BNE: begin ctrl_o.alu_op = ALU_SUB; ctrl_o.br_ne = 1'b1; end
      OP_J:   ctrl_o.jump = 1'b1;
      OP_LUI: begin ctrl_o.writeenable = 1'b1; ctrl_o.rd_src = 1'b1; ctrl_o.lui = 1'b1; end
      OP_LW: begin
        ctrl_o.alu_op = ALU_ADD; ctrl_o.writeenable = 1'b1; ctrl_o.rd_src = 1'b1;
        ctrl_o.alu_src2 = 1'b1; ctrl_o.mem_read = 1'b1;
      end
      OP_LBU: begin
        ctrl_o.alu_op = ALU_ADD; ctrl_o.writeenable = 1'b1; ctrl_o.rd_src = 1'b1;
        ctrl_o.alu_src2 = 1'b1; ctrl_o.mem_read = 1'b1; ctrl_o.byte_load = 1'b1;
      end
      OP_SW:  begin ctrl_o.alu_op = ALU_ADD; ctrl_o.alu_src2 = 1'b1; ctrl_o.word_we = 1'b1; end
      OP_SB:  begin ctrl_o.alu_op = ALU_ADD; ctrl_o.alu_src2 = 1'b1; ctrl_o.byte_we = 1'b1; end
      default: ctrl_o.except = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_decode_pipe.sv
// Registered decode stage: one-entry output register with valid/ready, addm split, exception counter.
module mips_decode_pipe
  import mips_defs::*;
#(
  parameter int unsigned PC_W       = 32,
  parameter bit          ADDM_SPLIT = 1'b1,
  parameter int unsigned EXC_CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSN_W-1:0]    in_insn,
  input  logic [PC_W-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [REG_W-1:0]     rs,
  output logic [REG_W-1:0]     rt,
  output logic [REG_W-1:0]     rd,
  output logic [IMM_W-1:0]     imm16,
  output logic [TGT_W-1:0]     target26,
  output logic [ALU_W-1:0]     alu_op,
  output logic                 writeenable,
  output logic                 rd_src,
  output logic                 alu_src2,
  output logic                 except,
  output logic                 br_eq,
  output logic                 br_ne,
  output logic                 jump,
  output logic                 jump_reg,
  output logic                 mem_read,
  output logic                 word_we,
  output logic                 byte_we,
  output logic                 byte_load,
  output logic                 lui,
  output logic                 slt,
  output logic                 addm,
  output logic                 uop,
  output logic [EXC_CNT_W-1:0] exc_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_ADDM1 = 2'd2;
  localparam logic [EXC_CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]           state_q, state_d;
  logic                 vld_q, vld_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 uop_q, uop_d;
  logic [REG_W-1:0]     save_rs_q, save_rs_d;
  logic [IMM_W-1:0]     save_imm_q, save_imm_d;
  logic [EXC_CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t dec;
  logic  accept;
  logic  deliver;

  mips_decode_comb u_dec (
    .insn_i (in_insn),
    .ctrl_o (dec)
  );

  assign in_ready = !flush && (state_q != ST_ADDM1) && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign deliver  = vld_q && out_ready && !flush;

  // Next-state: flush beats accept beats advance; addm first micro-op reads mem[rt] (rs<-rt, imm16<-0)
  always_comb begin
    state_d    = state_q;
    vld_d      = vld_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    uop_d      = uop_q;
    save_rs_d  = save_rs_q;
    save_imm_d = save_imm_q;
    cnt_d      = cnt_q;
    if (flush) begin
      state_d = ST_EMPTY;
      vld_d   = 1'b0;
    end else if (accept) begin
      vld_d  = 1'b1;
      pc_d   = in_pc;
      uop_d  = 1'b0;
      ctrl_d = dec;
      if (ADDM_SPLIT && dec.addm) begin
        save_rs_d          = dec.rs;
        save_imm_d         = dec.imm16;
        ctrl_d.rs          = dec.rt;
        ctrl_d.imm16       = '0;
        ctrl_d.mem_read    = 1'b1;
        ctrl_d.alu_op      = ALU_ADD;
        ctrl_d.alu_src2    = 1'b1;
        ctrl_d.writeenable = 1'b0;
        ctrl_d.rd_src      = 1'b0;
        ctrl_d.addm        = 1'b0;
        state_d            = ST_ADDM1;
      end else begin
        state_d = ST_FULL;
      end
    end else if (out_ready) begin
      case (state_q)
        ST_ADDM1: begin
          ctrl_d.rs          = save_rs_q;
          ctrl_d.imm16       = save_imm_q;
          ctrl_d.addm        = 1'b1;
          ctrl_d.writeenable = 1'b1;
          ctrl_d.rd_src      = 1'b0;
          ctrl_d.alu_op      = ALU_ADD;
          ctrl_d.alu_src2    = 1'b0;
          ctrl_d.mem_read    = 1'b0;
          uop_d              = 1'b1;
          state_d            = ST_FULL;
        end
        ST_FULL: begin
          state_d = ST_EMPTY;
          vld_d   = 1'b0;
        end
        default: ;
      endcase
    end
    if (deliver && ctrl_q.except && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + EXC_CNT_W'(1);
    end
  end

  // State and output register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      vld_q      <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      uop_q      <= 1'b0;
      save_rs_q  <= '0;
      save_imm_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      uop_q      <= uop_d;
      save_rs_q  <= save_rs_d;
      save_imm_q <= save_imm_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid   = vld_q;
  assign out_pc      = pc_q;
  assign uop         = uop_q;
  assign exc_count   = cnt_q;
  assign rs          = ctrl_q.rs;
  assign rt          = ctrl_q.rt;
  assign rd          = ctrl_q.rd;
  assign imm16       = ctrl_q.imm16;
  assign target26    = ctrl_q.target26;
  assign alu_op      = ctrl_q.alu_op;
  assign writeenable = ctrl_q.writeenable;
  assign rd_src      = ctrl_q.rd_src;
  assign alu_src2    = ctrl_q.alu_src2;
  assign except      = ctrl_q.except;
  assign br_eq       = ctrl_q.br_eq;
  assign br_ne       = ctrl_q.br_ne;
  assign jump        = ctrl_q.jump;
  assign jump_reg    = ctrl_q.jump_reg;
  assign mem_read    = ctrl_q.mem_read;
  assign word_we     = ctrl_q.word_we;
  assign byte_we     = ctrl_q.byte_we;
  assign byte_load   = ctrl_q.byte_load;
  assign lui         = ctrl_q.lui;
  assign slt         = ctrl_q.slt;
  assign addm        = ctrl_q.addm;

endmodule

// File: tb/tb_mips_decode_pipe.sv
// Bench for mips_decode_pipe: directed scenarios plus random traffic against an op-queue model.
module tb_mips_decode_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic        uop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [2:0]  alu_op;
    logic        we;
    logic        rd_src;
    logic        alu_src2;
    logic        exc;
    logic        br_eq;
    logic        br_ne;
    logic        jump;
    logic        jump_reg;
    logic        mem_read;
    logic        word_we;
    logic        byte_we;
    logic        byte_load;
    logic        lui;
    logic        slt;
    logic        addm;
  } op_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_insn = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [2:0]  alu_op;
  logic        writeenable, rd_src, alu_src2, except, br_eq, br_ne, jump, jump_reg;
  logic        mem_read, word_we, byte_we, byte_load, lui, slt, addm, uop;
  logic [7:0]  exc_count;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_pc;
  logic [4:0]  n_rs, n_rt, n_rd;
  logic [15:0] n_imm16;
  logic [25:0] n_target26;
  logic [2:0]  n_alu_op;
  logic        n_writeenable, n_rd_src, n_alu_src2, n_except, n_br_eq, n_br_ne, n_jump, n_jump_reg;
  logic        n_mem_read, n_word_we, n_byte_we, n_byte_load, n_lui, n_slt, n_addm, n_uop;
  logic [7:0]  n_exc_count;

  op_t obs;
  int  total = 0;
  int  bad = 0;

  always #5 clock = ~clock;

  mips_decode_pipe #(.PC_W(32), .ADDM_SPLIT(1'b1), .EXC_CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .target26(target26), .alu_op(alu_op), .writeenable(writeenable),
    .rd_src(rd_src), .alu_src2(alu_src2), .except(except), .br_eq(br_eq),
    .br_ne(br_ne), .jump(jump), .jump_reg(jump_reg), .mem_read(mem_read),
    .word_we(word_we), .byte_we(byte_we), .byte_load(byte_load), .lui(lui),
    .slt(slt), .addm(addm), .uop(uop), .exc_count(exc_count)
  );

  mips_decode_pipe #(.PC_W(32), .ADDM_SPLIT(1'b0), .EXC_CNT_W(8)) u_dut_ns (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .flush(flush), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_pc(n_out_pc), .rs(n_rs), .rt(n_rt), .rd(n_rd),
    .imm16(n_imm16), .target26(n_target26), .alu_op(n_alu_op), .writeenable(n_writeenable),
    .rd_src(n_rd_src), .alu_src2(n_alu_src2), .except(n_except), .br_eq(n_br_eq),
    .br_ne(n_br_ne), .jump(n_jump), .jump_reg(n_jump_reg), .mem_read(n_mem_read),
    .word_we(n_word_we), .byte_we(n_byte_we), .byte_load(n_byte_load), .lui(n_lui),
    .slt(n_slt), .addm(n_addm), .uop(n_uop), .exc_count(n_exc_count)
  );

  assign obs = '{pc: out_pc, uop: uop, rs: rs, rt: rt, rd: rd, imm16: imm16,
                 target26: target26, alu_op: alu_op, we: writeenable, rd_src: rd_src,
                 alu_src2: alu_src2, exc: except, br_eq: br_eq, br_ne: br_ne, jump: jump,
                 jump_reg: jump_reg, mem_read: mem_read, word_we: word_we, byte_we: byte_we,
                 byte_load: byte_load, lui: lui, slt: slt, addm: addm};

  // Reference decode: mnemonic-level view of what each instruction asks the datapath to do
  function automatic op_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    op_t o;
    logic [5:0] opc;
    logic [5:0] fn;
    bit imm_alu, load, store;
    o = '0;
    opc = w[31:26];
    fn = w[5:0];
    o.pc = pc; o.rs = w[25:21]; o.rt = w[20:16]; o.rd = w[15:11];
    o.imm16 = w[15:0]; o.target26 = w[25:0];
    imm_alu = (opc == 6'h08) || (opc == 6'h09) || (opc == 6'h0c) || (opc == 6'h0d) || (opc == 6'h0e);
    load  = (opc == 6'h23) || (opc == 6'h24);
    store = (opc == 6'h2b) || (opc == 6'h28);
    if (opc == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21 || fn == 6'h2c) o.alu_op = 3'd2;
      else if (fn == 6'h22 || fn == 6'h2a) o.alu_op = 3'd3;
      else if (fn == 6'h24) o.alu_op = 3'd4;
      else if (fn == 6'h25) o.alu_op = 3'd5;
      else if (fn == 6'h27) o.alu_op = 3'd6;
      else if (fn == 6'h26) o.alu_op = 3'd7;
      if (fn == 6'h08) o.jump_reg = 1'b1;
      else if (o.alu_op != 3'd0) o.we = 1'b1;
      else o.exc = 1'b1;
      o.slt = (fn == 6'h2a);
      o.addm = (fn == 6'h2c);
      o.mem_read = (fn == 6'h2c);
    end else if (imm_alu || load || store) begin
      o.alu_op = (opc == 6'h0c) ? 3'd4 : (opc == 6'h0d) ? 3'd5 : (opc == 6'h0e) ? 3'd7 : 3'd2;
      o.alu_src2 = 1'b1;
      o.we = !store;
      o.rd_src = !store;
      o.mem_read = load;
      o.byte_load = (opc == 6'h24);
      o.word_we = (opc == 6'h2b);
      o.byte_we = (opc == 6'h28);
    end else if (opc == 6'h04 || opc == 6'h05) begin
      o.alu_op = 3'd3;
      o.br_eq = (opc == 6'h04);
      o.br_ne = (opc == 6'h05);
    end else if (opc == 6'h02) begin
      o.jump = 1'b1;
    end else if (opc == 6'h0f) begin
      o.we = 1'b1; o.rd_src = 1'b1; o.lui = 1'b1;
    end else begin
      o.exc = 1'b1;
    end
    return o;
  endfunction

  // addm first micro-op: load from mem[rt + 0], no register write
  function automatic op_t first_uop(input op_t o);
    op_t f;
    f = o;
    f.uop = 1'b0; f.rs = o.rt; f.imm16 = '0; f.mem_read = 1'b1; f.alu_op = 3'd2;
    f.alu_src2 = 1'b1; f.we = 1'b0; f.rd_src = 1'b0; f.addm = 1'b0;
    return f;
  endfunction

  // addm second micro-op: the add with the loaded value, no memory read
  function automatic op_t second_uop(input op_t o);
    op_t s;
    s = o;
    s.uop = 1'b1; s.mem_read = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0, 1: begin
        w[31:26] = 6'h00;
        case ($urandom_range(0, 10))
          0: w[5:0] = 6'h20;  1: w[5:0] = 6'h21;  2: w[5:0] = 6'h22;
          3: w[5:0] = 6'h24;  4: w[5:0] = 6'h25;  5: w[5:0] = 6'h26;
          6: w[5:0] = 6'h27;  7: w[5:0] = 6'h2a;  8: w[5:0] = 6'h08;
          9: w[5:0] = 6'h2c;  default: ;
        endcase
      end
      2: begin
        case ($urandom_range(0, 13))
          0: w[31:26] = 6'h08;  1: w[31:26] = 6'h09;  2: w[31:26] = 6'h0c;
          3: w[31:26] = 6'h0d;  4: w[31:26] = 6'h0e;  5: w[31:26] = 6'h04;
          6: w[31:26] = 6'h05;  7: w[31:26] = 6'h02;  8: w[31:26] = 6'h0f;
          9: w[31:26] = 6'h23;  10: w[31:26] = 6'h24; 11: w[31:26] = 6'h2b;
          12: w[31:26] = 6'h28; default: w[31:26] = 6'h3f;
        endcase
      end
      3: begin w[31:26] = 6'h00; w[5:0] = 6'h2c; end
      default: ;
    endcase
    return w;
  endfunction

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_insn = '0; in_pc = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (exc_count !== 8'd0) begin bad++; $display("FAIL reset_exc_count got=%0d exp=0", exc_count); end
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_fields got=%h exp=0", obs); end
    @(negedge clock); reset = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    flush = 1'b1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_flush got=%b exp=0", in_ready); end
    flush = 1'b0;
  endtask

  task automatic test_add();
    do_reset();
    in_valid = 1'b1; in_insn = 32'h00221820; in_pc = 32'h100; out_ready = 1'b1;
    @(negedge clock); in_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    total++;
    if (alu_op !== 3'b010 || writeenable !== 1'b1 || rd !== 5'd3 || rd_src !== 1'b0 || out_pc !== 32'h100) begin
      bad++; $display("FAIL add_ctrl got alu=%b we=%b rd=%0d rd_src=%b pc=%h exp alu=010 we=1 rd=3 rd_src=0 pc=100",
                      alu_op, writeenable, rd, rd_src, out_pc);
    end
    @(negedge clock); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_insn = 32'h10220004; in_pc = 32'h200; out_ready = 1'b0;
    @(negedge clock);
    in_insn = 32'h8C430008; in_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || br_eq !== 1'b1 || alu_op !== 3'b011 || writeenable !== 1'b0 || out_pc !== 32'h200) begin
        bad++; $display("FAIL beq_hold cyc=%0d got v=%b br_eq=%b alu=%b we=%b pc=%h exp v=1 br_eq=1 alu=011 we=0 pc=200",
                        k, out_valid, br_eq, alu_op, writeenable, out_pc);
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL beq_stall_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
      if (k < 2) @(negedge clock);
    end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    @(negedge clock); in_valid = 1'b0; #1;
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h204 || mem_read !== 1'b1 || writeenable !== 1'b1 || rd_src !== 1'b1 ||
        rt !== 5'd3 || imm16 !== 16'h0008 || br_eq !== 1'b0) begin
      bad++; $display("FAIL b2b_lw got v=%b pc=%h mr=%b we=%b rd_src=%b rt=%0d imm=%h exp v=1 pc=204 mr=1 we=1 rd_src=1 rt=3 imm=0008",
                      out_valid, out_pc, mem_read, writeenable, rd_src, rt, imm16);
    end
    @(negedge clock); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_addm();
    do_reset();
    in_valid = 1'b1; in_insn = 32'h0022182C; in_pc = 32'h300; out_ready = 1'b1;
    @(negedge clock); in_valid = 1'b0; #1;
    total++;
    if (out_valid !== 1'b1 || uop !== 1'b0 || mem_read !== 1'b1 || writeenable !== 1'b0 || addm !== 1'b0 ||
        out_pc !== 32'h300 || rs !== 5'd2 || imm16 !== 16'h0 || alu_src2 !== 1'b1 || alu_op !== 3'b010) begin
      bad++; $display("FAIL addm_uop0 got v=%b uop=%b mr=%b we=%b addm=%b pc=%h rs=%0d imm=%h src2=%b alu=%b",
                      out_valid, uop, mem_read, writeenable, addm, out_pc, rs, imm16, alu_src2, alu_op);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL addm_in_ready got=%b exp=0", in_ready); end
    total++;
    if (n_out_valid !== 1'b1 || n_addm !== 1'b1 || n_uop !== 1'b0 || n_writeenable !== 1'b1 || n_out_pc !== 32'h300) begin
      bad++; $display("FAIL addm_nosplit got v=%b addm=%b uop=%b we=%b pc=%h exp v=1 addm=1 uop=0 we=1 pc=300",
                      n_out_valid, n_addm, n_uop, n_writeenable, n_out_pc);
    end
    @(negedge clock); #1;
    total++;
    if (out_valid !== 1'b1 || uop !== 1'b1 || addm !== 1'b1 || writeenable !== 1'b1 || mem_read !== 1'b0 ||
        rd_src !== 1'b0 || out_pc !== 32'h300 || rs !== 5'd1 || rd !== 5'd3) begin
      bad++; $display("FAIL addm_uop1 got v=%b uop=%b addm=%b we=%b mr=%b rd_src=%b pc=%h rs=%0d rd=%0d",
                      out_valid, uop, addm, writeenable, mem_read, rd_src, out_pc, rs, rd);
    end
    total++; if (n_out_valid !== 1'b0) begin bad++; $display("FAIL addm_nosplit_single got=%b exp=0", n_out_valid); end
    @(negedge clock); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addm_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_insn = 32'h0022182C; in_pc = 32'h400; out_ready = 1'b0;
    @(negedge clock);
    in_insn = 32'h00221820; in_pc = 32'h404; flush = 1'b1; #1;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_pre got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready);
    end
    @(negedge clock); flush = 1'b0; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_kill got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    @(negedge clock); in_valid = 1'b0; out_ready = 1'b1; #1;
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h404 || uop !== 1'b0 || addm !== 1'b0 || writeenable !== 1'b1) begin
      bad++; $display("FAIL flush_next got v=%b pc=%h uop=%b addm=%b we=%b exp v=1 pc=404 uop=0 addm=0 we=1",
                      out_valid, out_pc, uop, addm, writeenable);
    end
    @(negedge clock); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_uop1 got v=%b uop=%b exp v=0", out_valid, uop); end
  endtask

  task automatic test_exc_saturate();
    int exp_cnt;
    do_reset();
    in_valid = 1'b1; in_insn = 32'hFC000000; in_pc = '0; out_ready = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clock); in_pc = 32'(k * 4); #1;
      exp_cnt = (k - 1 > 255) ? 255 : k - 1;
      total++;
      if (out_valid !== 1'b1 || except !== 1'b1 || writeenable !== 1'b0) begin
        bad++; $display("FAIL exc_op k=%0d got v=%b exc=%b we=%b exp v=1 exc=1 we=0", k, out_valid, except, writeenable);
      end
      total++; if (exc_count !== 8'(exp_cnt)) begin
        bad++; $display("FAIL exc_count k=%0d got=%0d exp=%0d", k, exc_count, exp_cnt);
      end
    end
    in_valid = 1'b0;
    @(negedge clock); #1;
    total++; if (exc_count !== 8'd255) begin bad++; $display("FAIL exc_saturated got=%0d exp=255", exc_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_insn = 32'hFC000000; in_pc = 32'h500; out_ready = 1'b1;
    @(negedge clock);
    in_insn = 32'h0022182C; in_pc = 32'h504;
    @(negedge clock); in_valid = 1'b0; out_ready = 1'b0; #1;
    total++; if (out_valid !== 1'b1 || uop !== 1'b0 || mem_read !== 1'b1 || exc_count !== 8'd1) begin
      bad++; $display("FAIL areset_pre got v=%b uop=%b mr=%b cnt=%0d exp v=1 uop=0 mr=1 cnt=1", out_valid, uop, mem_read, exc_count);
    end
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || exc_count !== 8'd0) begin
      bad++; $display("FAIL areset_now got v=%b cnt=%0d exp v=0 cnt=0", out_valid, exc_count);
    end
    total++; if (obs !== '0) begin bad++; $display("FAIL areset_fields got=%h exp=0", obs); end
    @(negedge clock); reset = 1'b1; #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL areset_after got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_random(input int n);
    op_t m_op, m_pend, nop;
    bit  m_held, m_pend_v, exp_rdy, acc;
    int  m_exc;
    do_reset();
    m_op = '0; m_pend = '0; m_held = 1'b0; m_pend_v = 1'b0; m_exc = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_insn   = rand_insn();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      exp_rdy = !flush && !m_pend_v && (!m_held || out_ready);
      total++; if (in_ready !== exp_rdy) begin
        bad++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_rdy);
      end
      total++; if (out_valid !== m_held) begin
        bad++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, out_valid, m_held);
      end
      if (m_held) begin
        total++; if (obs !== m_op) begin
          bad++; $display("FAIL rand_op cyc=%0d got=%h exp=%h", c, obs, m_op);
        end
      end
      total++; if (exc_count !== 8'(m_exc)) begin
        bad++; $display("FAIL rand_exc_count cyc=%0d got=%0d exp=%0d", c, exc_count, m_exc);
      end
      acc = in_valid && exp_rdy;
      nop = ref_decode(in_insn, in_pc);
      @(posedge clock);
      if (flush) begin
        m_held = 1'b0; m_pend_v = 1'b0;
      end else begin
        if (m_held && out_ready) begin
          if (m_op.exc && m_exc < 255) m_exc++;
          if (m_pend_v) begin m_op = m_pend; m_pend_v = 1'b0; end
          else m_held = 1'b0;
        end
        if (acc) begin
          m_held = 1'b1;
          if (nop.addm) begin
            m_op = first_uop(nop); m_pend = second_uop(nop); m_pend_v = 1'b1;
          end else begin
            m_op = nop;
          end
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_addm();
    test_flush();
    test_exc_saturate();
    test_async_reset();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
